// File: rtl/regfile8_onehot.sv
// 8 x WIDTH register file with a one-hot write select and two combinational read ports.
// Multi-hot write selects are dropped entirely and latch a sticky error flag until reset.
module regfile8_onehot #(
  parameter int WIDTH    = 32,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b0
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [7:0]       wr_sel_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic [2:0]       rd_addr_a_i,
  input  logic [2:0]       rd_addr_b_i,
  output logic [WIDTH-1:0] rd_data_a_o,
  output logic [WIDTH-1:0] rd_data_b_o,
  output logic             err_o
);

  logic [WIDTH-1:0] regs_q [8];
  logic [WIDTH-1:0] regs_d [8];
  logic             err_q;
  logic             err_d;
  logic             sel_one_hot;
  logic             sel_multi_hot;

  always_comb begin
    sel_one_hot   = $onehot(wr_sel_i);
    sel_multi_hot = (wr_sel_i != 8'h00) && !sel_one_hot;
  end

  // Entry 0 is never loaded when hardwired to zero, so it keeps its reset value.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      regs_d[i] = regs_q[i];
      if (sel_one_hot && wr_sel_i[i] && !(ZERO_REG && (i == 0))) begin
        regs_d[i] = wr_data_i;
      end
    end
    err_d = err_q | sel_multi_hot;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= '0;
      end
      err_q <= 1'b0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= regs_d[i];
      end
      err_q <= err_d;
    end
  end

  logic hit_a;
  logic hit_b;
  logic zero_a;
  logic zero_b;

  // Forwarding only applies to a clean single-entry write that will actually land.
  always_comb begin
    zero_a = ZERO_REG && (rd_addr_a_i == 3'd0);
    zero_b = ZERO_REG && (rd_addr_b_i == 3'd0);
    hit_a  = BYPASS && !reset_i && sel_one_hot && wr_sel_i[rd_addr_a_i];
    hit_b  = BYPASS && !reset_i && sel_one_hot && wr_sel_i[rd_addr_b_i];
  end

  always_comb begin
    if (zero_a) begin
      rd_data_a_o = '0;
    end else if (hit_a) begin
      rd_data_a_o = wr_data_i;
    end else begin
      rd_data_a_o = regs_q[rd_addr_a_i];
    end
  end

  always_comb begin
    if (zero_b) begin
      rd_data_b_o = '0;
    end else if (hit_b) begin
      rd_data_b_o = wr_data_i;
    end else begin
      rd_data_b_o = regs_q[rd_addr_b_i];
    end
  end

  assign err_o = err_q;

endmodule
